fnd_scan_decoder: RTL and testbench
===================================

// Module: fnd_scan_decoder
// PURPOSE
//  Reverse end of the 4-digit multiplexed FND interface. Samples the scanned seg/an bus (the
//  vending machine top's outputs) and rebuilds the four displayed digits and their binary
//  value (0..9999). Flags frames that hold non-numeric patterns (coffee animation).
//  Used as a self-check monitor on-board and as the scoreboard front end in benches.
// PARAMETERS
//  SETTLE_CYCLES  4        an/seg must be unchanged this many clk before a digit is captured
//  MATCH_FRAMES   2        consecutive identical complete frames required before publishing
//  TIMEOUT_CYCLES 2000000  clk with no new digit capture before o_stall asserts (20 ms @100MHz)
// PORTS
//  clk          in   1   100 MHz system clock
//  reset        in   1   asynchronous, active-high; clears all state
//  i_seg        in   8   segment bus, active-low, bit order {dp,g,f,e,d,c,b,a}
//  i_an         in   4   digit select, active-low; an[0] = rightmost (ones) digit
//  o_bcd        out  16  published digits {d3,d2,d1,d0}, 4-bit BCD each
//  o_value      out  14  published binary value d3*1000+d2*100+d1*10+d0
//  o_valid      out  1   1-clk pulse when o_bcd/o_value update
//  o_blank      out  4   per digit: published digit was all-off (decoded as 0)
//  o_anim       out  1   level: last complete frame contained a non-numeric pattern
//  o_frame_err  out  1   1-clk pulse: illegal an (>1 bit low) seen; current frame discarded
//  o_stall      out  1   level: no digit captured for TIMEOUT_CYCLES
// BEHAVIOUR
//  - One clock, async active-high reset. Reset values: o_bcd=0, o_value=0, o_valid=0,
//    o_blank=4'b1111, o_anim=0, o_frame_err=0, o_stall=0; capture mask, counters, FSM cleared.
//  - i_seg/i_an pass through a 2-flop synchronizer (monitored bus may be off-chip).
//  - an classification (synced): exactly one bit low = digit k; all high = gap (ignored,
//    settle counter held at 0); >1 bit low = illegal.
//  - FSM: WAIT -> SETTLE on legal digit select; SETTLE counts clk while {an,seg} unchanged,
//    any change restarts count; at SETTLE_CYCLES capture digit k -> DONE; DONE holds until an
//    changes, then back to WAIT/SETTLE. Each digit is captured at most once per scan slot.
//  - Pattern decode (7 LSBs, dp ignored): standard 0..9 -> BCD; 7'h7F (all off) -> 0 + blank;
//    anything else -> 0 + non-numeric flag for that digit.
//  - Frame: 4-bit capture mask; capturing an already-set digit restarts the mask with that
//    digit (stale partial frame dropped). Mask==4'b1111 closes the frame on that clk.
//  - On frame close: compare {digits,blank,nonnum} with previous closed frame; equal ->
//    match count +1 (saturating), else count = 1. o_anim updates on every frame close.
//  - When count reaches MATCH_FRAMES and frame is fully numeric: BCD->binary registered
//    one stage; o_bcd/o_value/o_blank update and o_valid pulses 2 clk after frame close.
//    Identical later frames do not re-pulse o_valid until the content changes.
//  - Non-numeric frames never update o_bcd/o_value; they reset the match count.
//  - Illegal an: o_frame_err pulses next clk, mask and match count cleared, FSM -> WAIT.
//  - Timeout counter clears on each digit capture; saturates; o_stall = saturated.
//    o_stall drops on the next capture.
//  - Arithmetic: d*1000 etc. via shift-add in 14 bits; max 9999 fits, no overflow possible.
//  - Reset mid-frame: everything cleared asynchronously; first publish needs MATCH_FRAMES
//    fresh complete frames.
// STRUCTURE
//  - Shared include fnd_defs.vh: active-low 7-seg constants SEG_0..SEG_9, SEG_BLANK,
//    digit count, AN_ALL_OFF; the encoder side uses the same file.
//  - Sub-module fnd_pattern_decode (combinational): 7-bit pattern -> {bcd[3:0],blank,nonnum}.
//  - Top: synchronizer, settle FSM, frame assembler, match counter, BCD->bin stage, timeout.
// TESTING
//  1 Scan d3..d0 = 8'hF9,8'hA4,8'hB0,8'h99 (an 0111..1110), 2 frames -> o_value=1234,
//    o_bcd=16'h1234, one o_valid pulse 2 clk after 2nd frame close.
//  2 Value 0500 with d3 blank (8'hFF) -> o_value=500, o_blank=4'b1000; o_valid once.
//  3 Rotating outer-segment pattern (8'hFE,8'hFD..) on all digits -> o_anim=1,
//    o_value stays 1234, no o_valid; return to 1234 for 2 frames -> o_anim=0, no re-pulse.
//  4 an=4'b0011 mid-frame -> o_frame_err one pulse; next 2 good frames of 0100 -> o_value=100.
//  5 Glitch: seg changes 2 clk into digit slot (SETTLE_CYCLES=4) -> glitch value ignored,
//    final stable value captured; also 9999 -> o_value=9999.
//  6 Hold an=4'b1111 for TIMEOUT_CYCLES (bench TIMEOUT=100) -> o_stall=1; resume -> 0;
//    assert reset mid-frame -> all outputs at reset values same clk.

Source files
------------

// File: rtl/fnd_scan_decoder_pkg.sv
// ============================================================================
// Module  : fnd_scan_decoder_pkg
// Brief   : Shared 7-segment constants, FSM encodings and BCD helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fnd_scan_decoder_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] AN_ALL_OFF = 4'hF;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic [3:0]  nonnum;
  } frame_t;

  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    logic [13:0] d3, d2, d1, d0;
    d3 = {10'd0, bcd[15:12]};
    d2 = {10'd0, bcd[11:8]};
    d1 = {10'd0, bcd[7:4]};
    d0 = {10'd0, bcd[3:0]};
    // 1000 = 512+256+128+64+32+8, 100 = 64+32+4, 10 = 8+2
    return (d3 << 9) + (d3 << 8) + (d3 << 7) + (d3 << 6) + (d3 << 5) + (d3 << 3)
         + (d2 << 6) + (d2 << 5) + (d2 << 2)
         + (d1 << 3) + (d1 << 1)
         + d0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_pattern_decode.sv
// ============================================================================
// Module  : fnd_pattern_decode
// Brief   : Combinational 7-segment pattern to {bcd, blank, non-numeric}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fnd_pattern_decode
  import fnd_scan_decoder_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_bcd,
  output logic       o_blank,
  output logic       o_nonnum
);

  always_comb begin
    o_bcd    = 4'd0;
    o_blank  = 1'b0;
    o_nonnum = 1'b0;
    case (i_pat)
      SEG_0:     o_bcd = 4'd0;
      SEG_1:     o_bcd = 4'd1;
      SEG_2:     o_bcd = 4'd2;
      SEG_3:     o_bcd = 4'd3;
      SEG_4:     o_bcd = 4'd4;
      SEG_5:     o_bcd = 4'd5;
      SEG_6:     o_bcd = 4'd6;
      SEG_7:     o_bcd = 4'd7;
      SEG_8:     o_bcd = 4'd8;
      SEG_9:     o_bcd = 4'd9;
      SEG_BLANK: o_blank = 1'b1;
      default:   o_nonnum = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_decoder.sv
// ============================================================================
// Module  : fnd_scan_decoder
// Brief   : Rebuilds the 4 displayed digits and binary value from a scanned FND bus.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fnd_scan_decoder
  import fnd_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int MATCH_FRAMES   = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_seg,
  input  logic [3:0]  i_an,
  output logic [15:0] o_bcd,
  output logic [13:0] o_value,
  output logic        o_valid,
  output logic [3:0]  o_blank,
  output logic        o_anim,
  output logic        o_frame_err,
  output logic        o_stall
);

  localparam int c_SW = $clog2(SETTLE_CYCLES + 1);
  localparam int c_MW = $clog2(MATCH_FRAMES + 1);
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]      r_seg_s1, r_seg_s2, r_seg_q;
  logic [3:0]      r_an_s1, r_an_s2, r_an_q;
  logic [1:0]      r_state, w_state_nxt;
  logic [c_SW-1:0] r_settle;
  logic            w_gap, w_sel, w_illegal, w_changed, w_an_changed, w_capture;
  logic [1:0]      w_k;
  logic [3:0]      w_pd_bcd, w_bit, w_mask_nxt, r_mask;
  logic            w_pd_blank, w_pd_nn, w_close, w_same, w_numeric, w_pub;
  frame_t          r_dig, w_frame, r_last;
  logic            r_last_vld, r_pub_seen, r_ill_d, r_p_go;
  logic [c_MW-1:0] r_match, w_match_nxt;
  logic [15:0]     r_p_bcd;
  logic [3:0]      r_p_blk;
  logic [c_TW-1:0] r_to;

  // Two-flop synchronizer plus one extra stage used for change detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg_s1 <= 8'hFF; r_seg_s2 <= 8'hFF; r_seg_q <= 8'hFF;
      r_an_s1  <= AN_ALL_OFF; r_an_s2 <= AN_ALL_OFF; r_an_q <= AN_ALL_OFF;
    end else begin
      r_seg_s1 <= i_seg; r_seg_s2 <= r_seg_s1; r_seg_q <= r_seg_s2;
      r_an_s1  <= i_an;  r_an_s2  <= r_an_s1;  r_an_q  <= r_an_s2;
    end
  end

  always_comb begin
    w_gap = (r_an_s2 == AN_ALL_OFF);
    w_sel = 1'b1;
    w_k   = 2'd0;
    case (r_an_s2)
      4'b1110: w_k = 2'd0;
      4'b1101: w_k = 2'd1;
      4'b1011: w_k = 2'd2;
      4'b0111: w_k = 2'd3;
      default: w_sel = 1'b0;
    endcase
    w_illegal    = !w_gap && !w_sel;
    w_changed    = {r_an_s2, r_seg_s2} != {r_an_q, r_seg_q};
    w_an_changed = (r_an_s2 != r_an_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_WAIT;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE && !w_changed)
                  ? r_settle + c_SW'(1) : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_illegal) begin
      w_state_nxt = ST_WAIT;
    end else begin
      case (r_state)
        ST_WAIT:   if (w_sel) w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (w_gap) w_state_nxt = ST_WAIT;
                   else if (w_capture) w_state_nxt = ST_DONE;
        ST_DONE:   if (w_an_changed) w_state_nxt = w_sel ? ST_SETTLE : ST_WAIT;
        default:   w_state_nxt = ST_WAIT;
      endcase
    end
  end

  always_comb begin
    w_capture = (r_state == ST_SETTLE) && w_sel && !w_changed
                && (r_settle == c_SW'(SETTLE_CYCLES - 1));
  end

  fnd_pattern_decode u_decode (
    .i_pat    (r_seg_s2[6:0]),
    .o_bcd    (w_pd_bcd),
    .o_blank  (w_pd_blank),
    .o_nonnum (w_pd_nn)
  );

  // Frame content as it would look including the digit captured this clk
  always_comb begin
    w_frame    = r_dig;
    w_mask_nxt = r_mask;
    w_bit      = 4'b0001 << w_k;
    if (w_capture) begin
      w_frame.bcd[{w_k, 2'b00} +: 4] = w_pd_bcd;
      w_frame.blank[w_k]             = w_pd_blank;
      w_frame.nonnum[w_k]            = w_pd_nn;
      w_mask_nxt = r_mask[w_k] ? w_bit : (r_mask | w_bit);
    end
    w_close   = w_capture && (w_mask_nxt == 4'hF);
    w_same    = r_last_vld && (w_frame == r_last);
    w_numeric = ~|w_frame.nonnum;
    if (!w_numeric)
      w_match_nxt = '0;
    else if (w_same)
      w_match_nxt = (r_match == c_MW'(MATCH_FRAMES)) ? r_match : r_match + c_MW'(1);
    else
      w_match_nxt = c_MW'(1);
    w_pub = w_close && w_numeric && (w_match_nxt == c_MW'(MATCH_FRAMES))
            && !(w_same && r_match == c_MW'(MATCH_FRAMES))
            && (!r_pub_seen || {w_frame.bcd, w_frame.blank} != {o_bcd, o_blank});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask      <= '0;
      r_dig       <= '0;
      r_last      <= '0;
      r_last_vld  <= 1'b0;
      r_match     <= '0;
      r_pub_seen  <= 1'b0;
      r_ill_d     <= 1'b0;
      o_frame_err <= 1'b0;
      o_anim      <= 1'b0;
    end else begin
      r_ill_d     <= w_illegal;
      o_frame_err <= w_illegal && !r_ill_d;
      if (w_capture) r_dig <= w_frame;
      if (w_illegal) begin
        r_mask  <= '0;
        r_match <= '0;
      end else if (w_close) begin
        r_mask     <= '0;
        r_match    <= w_match_nxt;
        r_last     <= w_frame;
        r_last_vld <= 1'b1;
        o_anim     <= !w_numeric;
      end else begin
        r_mask <= w_mask_nxt;
      end
      if (w_pub) r_pub_seen <= 1'b1;
    end
  end

  // Publish pipeline: latch frame, then convert and drive outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p_go  <= 1'b0;
      r_p_bcd <= '0;
      r_p_blk <= '0;
      o_valid <= 1'b0;
      o_bcd   <= '0;
      o_value <= '0;
      o_blank <= 4'b1111;
    end else begin
      r_p_go  <= w_pub;
      if (w_pub) begin
        r_p_bcd <= w_frame.bcd;
        r_p_blk <= w_frame.blank;
      end
      o_valid <= r_p_go;
      if (r_p_go) begin
        o_bcd   <= r_p_bcd;
        o_value <= bcd_to_bin(r_p_bcd);
        o_blank <= r_p_blk;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_to <= '0;
    else if (w_capture)
      r_to <= '0;
    else if (r_to != c_TW'(TIMEOUT_CYCLES))
      r_to <= r_to + c_TW'(1);
  end

  assign o_stall = (r_to == c_TW'(TIMEOUT_CYCLES));

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
// ============================================================================
// Module  : tb_fnd_scan_decoder
// Brief   : Table-driven scan frames with a publish scoreboard, plus corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fnd_scan_decoder;

  localparam int SETTLE = 4;
  localparam int MATCH  = 2;
  localparam int TMO    = 100;
  localparam int SLOT   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] o_bcd;
  logic [13:0] o_value;
  logic        o_valid;
  logic [3:0]  o_blank;
  logic        o_anim;
  logic        o_frame_err;
  logic        o_stall;

  fnd_scan_decoder #(
    .SETTLE_CYCLES  (SETTLE),
    .MATCH_FRAMES   (MATCH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_seg       (seg),
    .i_an        (an),
    .o_bcd       (o_bcd),
    .o_value     (o_value),
    .o_valid     (o_valid),
    .o_blank     (o_blank),
    .o_anim      (o_anim),
    .o_frame_err (o_frame_err),
    .o_stall     (o_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic [13:0] val;
    logic [3:0]  blk;
  } exp_t;

  typedef struct {
    logic [31:0] segs;
    int          reps;
    bit          pub;
    logic [15:0] bcd;
    logic [13:0] val;
    logic [3:0]  blk;
    bit          anim;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_ferr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_frame_err) n_ferr++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got pulse with value %0d, expected no pulse", o_value);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pub_bcd",   o_bcd,   e.bcd);
          check("pub_value", o_value, e.val);
          check("pub_blank", o_blank, e.blk);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input int k, input logic [7:0] s);
    an  = 4'hF ^ (4'b0001 << k);
    seg = s;
    tick(SLOT);
  endtask

  task automatic gap(input int n);
    an  = 4'hF;
    seg = 8'hFF;
    tick(n);
  endtask

  task automatic frame(input logic [31:0] segs);
    for (int k = 3; k >= 0; k--) slot(k, segs[k*8 +: 8]);
    gap(2);
  endtask

  task automatic push(input logic [15:0] b, input logic [13:0] v, input logic [3:0] bl);
    exp_t e;
    e.bcd = b; e.val = v; e.blk = bl;
    sb.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ferr0;
    tbl[0] = '{32'hF9A4B099, 2, 1'b1, 16'h1234, 14'd1234, 4'b0000, 1'b0};
    tbl[1] = '{32'hFF92C0C0, 3, 1'b1, 16'h0500, 14'd500,  4'b1000, 1'b0};
    tbl[2] = '{32'hF9A4B099, 2, 1'b1, 16'h1234, 14'd1234, 4'b0000, 1'b0};
    tbl[3] = '{32'hFEFDFBF7, 1, 1'b0, 16'h1234, 14'd1234, 4'b0000, 1'b1};
    tbl[4] = '{32'hFDFBF7EF, 1, 1'b0, 16'h1234, 14'd1234, 4'b0000, 1'b1};
    tbl[5] = '{32'hFBF7EFDF, 1, 1'b0, 16'h1234, 14'd1234, 4'b0000, 1'b1};
    tbl[6] = '{32'hF9A4B099, 2, 1'b0, 16'h1234, 14'd1234, 4'b0000, 1'b0};
    tbl[7] = '{32'hF9A4B099, 1, 1'b0, 16'h1234, 14'd1234, 4'b0000, 1'b0};

    reset = 1'b1; an = 4'hF; seg = 8'hFF;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_bcd",   o_bcd,       16'h0);
    check("rst_value", o_value,     14'd0);
    check("rst_valid", o_valid,     1'b0);
    check("rst_blank", o_blank,     4'b1111);
    check("rst_anim",  o_anim,      1'b0);
    check("rst_ferr",  o_frame_err, 1'b0);
    check("rst_stall", o_stall,     1'b0);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pub) push(tbl[i].bcd, tbl[i].val, tbl[i].blk);
      for (int r = 0; r < tbl[i].reps; r++) frame(tbl[i].segs);
      tick(10);
      check("tbl_pending", sb.size(), 0);
      check("tbl_value",   o_value,   tbl[i].val);
      check("tbl_bcd",     o_bcd,     tbl[i].bcd);
      check("tbl_blank",   o_blank,   tbl[i].blk);
      check("tbl_anim",    o_anim,    tbl[i].anim);
    end
    check("stall_idle", o_stall, 1'b0);

    // illegal digit select mid-frame
    ferr0 = n_ferr;
    slot(3, 8'hC0);
    slot(2, 8'hF9);
    an = 4'b0011;
    tick(4);
    gap(4);
    check("ferr_pulses", n_ferr - ferr0, 1);
    push(16'h0100, 14'd100, 4'b0000);
    frame(32'hC0F9C0C0);
    frame(32'hC0F9C0C0);
    tick(10);
    check("ill_pending", sb.size(), 0);
    check("ill_value",   o_value,   14'd100);

    // short glitch at the start of every slot must not be captured
    push(16'h9999, 14'd9999, 4'b0000);
    for (int f = 0; f < 2; f++) begin
      for (int k = 3; k >= 0; k--) begin
        an  = 4'hF ^ (4'b0001 << k);
        seg = 8'hC0;
        tick(2);
        seg = 8'h90;
        tick(SLOT);
      end
      gap(2);
    end
    tick(10);
    check("glitch_pending", sb.size(), 0);
    check("glitch_value",   o_value,   14'd9999);
    check("glitch_bcd",     o_bcd,     16'h9999);

    // timeout with the bus idle, then recovery
    gap(TMO + 20);
    check("stall_set", o_stall, 1'b1);
    frame(32'h90909090);
    check("stall_clr", o_stall, 1'b0);

    // asynchronous reset in the middle of a frame
    slot(3, 8'hF9);
    slot(2, 8'hA4);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mrst_bcd",   o_bcd,       16'h0);
    check("mrst_value", o_value,     14'd0);
    check("mrst_valid", o_valid,     1'b0);
    check("mrst_blank", o_blank,     4'b1111);
    check("mrst_anim",  o_anim,      1'b0);
    check("mrst_ferr",  o_frame_err, 1'b0);
    check("mrst_stall", o_stall,     1'b0);
    an = 4'hF; seg = 8'hFF;
    tick(2);
    reset = 1'b0;
    tick(3);
    frame(32'hF9A4B099);
    tick(10);
    check("mrst_one_frame", o_value, 14'd0);
    push(16'h1234, 14'd1234, 4'b0000);
    frame(32'hF9A4B099);
    tick(10);
    check("mrst_pending", sb.size(), 0);
    check("mrst_value",   o_value,   14'd1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
